// File: rtl/multicycle_controller_v2.sv
// RV32I multicycle control unit: main FSM, ALU decoder, immediate decoder and PC-write logic.
// Moore controls are registered alongside the state; fetch/branch qualifiers stay combinational.
module multicycle_controller_v2 #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int ALU_CTRL_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  input  logic                  Lt,
  input  logic                  Ltu,
  input  logic                  mem_ready,
  output logic                  MemReq,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  PCWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [2:0]            ImmSrc,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALRWB, UPPERWB, TRAP
  } state_t;

  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FN} aluop_t;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       regwrite;
    logic       adrsrc;
    logic       pcupd;
    logic       branch;
    logic       trap;
    logic [1:0] ressrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    aluop_t     aluop;
  } ctl_t;

  function automatic ctl_t ctl_of(state_t s, logic op5);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.memreq = 1'b1; c.srcb = 2'b10; c.ressrc = 2'b10; end
      DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      MEMREAD:  begin c.memreq = 1'b1; c.adrsrc = 1'b1; end
      MEMWB:    begin c.ressrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.memreq = 1'b1; c.memwrite = 1'b1; c.adrsrc = 1'b1; end
      EXECR:    begin c.srca = 2'b10; c.aluop = AOP_FN; end
      EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = AOP_FN; end
      ALUWB:    c.regwrite = 1'b1;
      BRANCH:   begin c.srca = 2'b10; c.aluop = AOP_SUB; c.branch = 1'b1; end
      JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcupd = 1'b1; end
      JALR:     begin c.srca = 2'b10; c.srcb = 2'b01; c.ressrc = 2'b10; c.pcupd = 1'b1; end
      JALRWB:   begin c.srca = 2'b01; c.srcb = 2'b10; c.ressrc = 2'b10; c.regwrite = 1'b1; end
      // LUI selects ImmExt; AUIPC reuses OldPC+imm left in ALUOut by DECODE
      UPPERWB:  begin c.regwrite = 1'b1; c.ressrc = op5 ? 2'b11 : 2'b00; end
      TRAP:     c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t state, nxt;
  ctl_t   ctl;
  logic   rdy, taken, fetch, live;
  logic [3:0] alu4;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    nxt = state;
    case (state)
      FETCH:    if (rdy) nxt = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = EXECR;
          7'b0010011:             nxt = EXECI;
          7'b1100011:             nxt = BRANCH;
          7'b1101111:             nxt = JAL;
          7'b1100111:             nxt = JALR;
          7'b0110111, 7'b0010111: nxt = UPPERWB;
          default:                nxt = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR:   nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (rdy) nxt = MEMWB;
      MEMWRITE: if (rdy) nxt = FETCH;
      EXECR, EXECI, JAL: nxt = ALUWB;
      JALR:     nxt = JALRWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= ctl_of(FETCH, op[5]);
    end else begin
      state <= nxt;
      ctl   <= ctl_of(nxt, op[5]);
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = ~Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = ~Ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    alu4 = 4'd0;
    case (ctl.aluop)
      AOP_SUB: alu4 = 4'd1;
      AOP_FN: begin
        case (funct3)
          3'b000:  alu4 = (op[5] & funct7b5) ? 4'd1 : 4'd0;
          3'b001:  alu4 = 4'd7;
          3'b010:  alu4 = 4'd5;
          3'b011:  alu4 = 4'd6;
          3'b100:  alu4 = 4'd4;
          3'b101:  alu4 = funct7b5 ? 4'd9 : 4'd8;
          3'b110:  alu4 = 4'd3;
          default: alu4 = 4'd2;
        endcase
      end
      default: alu4 = 4'd0;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // reset masks every strobe so nothing fires in the reset cycle, whatever state we left
  assign live       = ~reset;
  assign fetch      = (state == FETCH);
  assign MemReq     = live & ctl.memreq;
  assign MemWrite   = live & ctl.memwrite;
  assign RegWrite   = live & ctl.regwrite;
  assign IRWrite    = live & fetch & rdy;
  assign PCWrite    = live & ((fetch & rdy) | ctl.pcupd | (ctl.branch & taken));
  assign illegal    = live & ctl.trap;
  assign AdrSrc     = ctl.adrsrc;
  assign ResultSrc  = ctl.ressrc;
  assign ALUSrcA    = ctl.srca;
  assign ALUSrcB    = ctl.srcb;
  assign ALUControl = ALU_CTRL_W'(alu4);
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_controller_v2.sv
// Bench for multicycle_controller_v2: per-instruction expected state sequences plus
// per-state output tables, checked every cycle; a second instance covers TRAP_ON_ILLEGAL=0.
module tb_multicycle_controller_v2;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_JALR = 11, S_JALRWB = 12, S_UPPERWB = 13, S_TRAP = 14;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6,
                 C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  logic clk = 1'b0;
  logic reset, funct7b5, Zero, Lt, Ltu, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic MemReq, MemWrite, RegWrite, IRWrite, AdrSrc, PCWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl, state_dbg;
  logic [2:0] ImmSrc;
  logic z_MemReq, z_MemWrite, z_RegWrite, z_IRWrite, z_AdrSrc, z_PCWrite, z_illegal;
  logic [1:0] z_ResultSrc, z_ALUSrcA, z_ALUSrcB;
  logic [3:0] z_ALUControl, z_state_dbg;
  logic [2:0] z_ImmSrc;

  always #5 clk = ~clk;

  multicycle_controller_v2 dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .MemReq(MemReq), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .PCWrite(PCWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal),
    .state_dbg(state_dbg));

  multicycle_controller_v2 #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .MemReq(z_MemReq), .MemWrite(z_MemWrite), .RegWrite(z_RegWrite), .IRWrite(z_IRWrite),
    .AdrSrc(z_AdrSrc), .PCWrite(z_PCWrite), .ResultSrc(z_ResultSrc), .ALUSrcA(z_ALUSrcA),
    .ALUSrcB(z_ALUSrcB), .ALUControl(z_ALUControl), .ImmSrc(z_ImmSrc), .illegal(z_illegal),
    .state_dbg(z_state_dbg));

  typedef struct { int s; int s0; bit rdy; bit rst; } item_t;
  item_t q[$];

  int errors = 0, checks = 0;
  int cur_s, cur_s0;
  bit cur_rst, active = 1'b0, rnd_flags = 1'b0;
  int n_reg, n_ir, n_mw, n_pc, n_ill, n_trap_strobe, last_res, last_alu;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] opc(input int c);
    logic [6:0] ill [4];
    ill = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LD:    return 7'b0000011;
      C_ST:    return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      C_AUIPC: return 7'b0010111;
      default: return ill[$urandom_range(0, 3)];
    endcase
  endfunction

  // Reference tables: what each state must drive, from the control-signal definitions
  always @(negedge clk) begin : cmp
    int s, e_alu, e_res, e_a, e_b, e_imm;
    bit tk, in_mem;
    if (active) begin
      s = cur_s;
      if (cur_rst) begin
        chk("reset_strobes", {MemReq, MemWrite, RegWrite, IRWrite, PCWrite, illegal}, 0);
        chk("reset_strobes_nt", {z_MemReq, z_MemWrite, z_RegWrite, z_IRWrite, z_PCWrite}, 0);
      end else begin
        case (funct3)
          3'd0: tk = Zero;  3'd1: tk = !Zero;
          3'd4: tk = Lt;    3'd5: tk = !Lt;
          3'd6: tk = Ltu;   3'd7: tk = !Ltu;
          default: tk = 1'b0;
        endcase
        e_alu = 0;
        if (s == S_BRANCH) e_alu = 1;
        if (s == S_EXECR || s == S_EXECI)
          case (funct3)
            3'd0: e_alu = (op[5] && funct7b5) ? 1 : 0;
            3'd1: e_alu = 7;  3'd2: e_alu = 5;  3'd3: e_alu = 6;  3'd4: e_alu = 4;
            3'd5: e_alu = funct7b5 ? 9 : 8;
            3'd6: e_alu = 3;  default: e_alu = 2;
          endcase
        case (s)
          S_FETCH, S_JALR, S_JALRWB: e_res = 2;
          S_MEMWB:   e_res = 1;
          S_UPPERWB: e_res = op[5] ? 3 : 0;
          default:   e_res = 0;
        endcase
        e_a = (s == S_DECODE || s == S_JAL || s == S_JALRWB) ? 1 :
              (s == S_MEMADR || s == S_EXECR || s == S_EXECI || s == S_BRANCH || s == S_JALR) ? 2 : 0;
        e_b = (s == S_FETCH || s == S_JAL || s == S_JALRWB) ? 2 :
              (s == S_DECODE || s == S_MEMADR || s == S_EXECI || s == S_JALR) ? 1 : 0;
        case (op)
          7'b0100011: e_imm = 1;
          7'b1100011: e_imm = 2;
          7'b1101111: e_imm = 3;
          7'b0110111, 7'b0010111: e_imm = 4;
          default: e_imm = 0;
        endcase
        in_mem = (s == S_MEMREAD || s == S_MEMWRITE);
        chk("state", state_dbg, s);
        chk("MemReq", MemReq, (s == S_FETCH || in_mem) ? 1 : 0);
        chk("MemWrite", MemWrite, (s == S_MEMWRITE) ? 1 : 0);
        chk("RegWrite", RegWrite,
            (s == S_MEMWB || s == S_ALUWB || s == S_JALRWB || s == S_UPPERWB) ? 1 : 0);
        chk("IRWrite", IRWrite, (s == S_FETCH && mem_ready) ? 1 : 0);
        chk("AdrSrc", AdrSrc, in_mem ? 1 : 0);
        chk("PCWrite", PCWrite, ((s == S_FETCH && mem_ready) || s == S_JAL || s == S_JALR ||
                                 (s == S_BRANCH && tk)) ? 1 : 0);
        chk("ResultSrc", ResultSrc, e_res);
        chk("ALUSrcA", ALUSrcA, e_a);
        chk("ALUSrcB", ALUSrcB, e_b);
        chk("ALUControl", ALUControl, e_alu);
        chk("ImmSrc", ImmSrc, e_imm);
        chk("illegal", illegal, (s == S_TRAP) ? 1 : 0);
        chk("state_nt", z_state_dbg, cur_s0);
        chk("illegal_nt", z_illegal, 0);
        if (RegWrite) begin n_reg++; last_res = ResultSrc; end
        n_ir += IRWrite; n_mw += MemWrite; n_pc += PCWrite;
        if (state_dbg == 4'(S_TRAP)) begin
          n_ill += illegal;
          n_trap_strobe += MemReq + MemWrite + RegWrite + IRWrite + PCWrite;
        end
        if (state_dbg == 4'(S_EXECR)) last_alu = ALUControl;
      end
    end
  end

  task automatic push(input int s, input int s0, input bit rdy, input bit rst);
    item_t it;
    it.s = s; it.s0 = s0; it.rdy = rdy; it.rst = rst;
    q.push_back(it);
  endtask

  task automatic push_same(input int s, input bit rdy);
    push(s, s, rdy, 1'b0);
  endtask

  // Expected state walk of one instruction, with sf fetch stalls and sm memory stalls
  task automatic build(input int cls, input int sf, input int sm);
    repeat (sf) push_same(S_FETCH, 1'b0);
    push_same(S_FETCH, 1'b1);
    push_same(S_DECODE, 1'($urandom));
    case (cls)
      C_R:   begin push_same(S_EXECR, 1'($urandom)); push_same(S_ALUWB, 1'($urandom)); end
      C_I:   begin push_same(S_EXECI, 1'($urandom)); push_same(S_ALUWB, 1'($urandom)); end
      C_LD: begin
        push_same(S_MEMADR, 1'($urandom));
        repeat (sm) push_same(S_MEMREAD, 1'b0);
        push_same(S_MEMREAD, 1'b1);
        push_same(S_MEMWB, 1'($urandom));
      end
      C_ST: begin
        push_same(S_MEMADR, 1'($urandom));
        repeat (sm) push_same(S_MEMWRITE, 1'b0);
        push_same(S_MEMWRITE, 1'b1);
      end
      C_BR:  push_same(S_BRANCH, 1'($urandom));
      C_JAL: begin push_same(S_JAL, 1'($urandom)); push_same(S_ALUWB, 1'($urandom)); end
      C_JALR: begin push_same(S_JALR, 1'($urandom)); push_same(S_JALRWB, 1'($urandom)); end
      C_LUI, C_AUIPC: push_same(S_UPPERWB, 1'($urandom));
      default: begin
        // trapping instance sits in TRAP; the other keeps refetching the same bad opcode
        for (int i = 0; i < 10; i++) push(S_TRAP, (i % 2 == 0) ? S_FETCH : S_DECODE, 1'b1, 1'b0);
        push(S_FETCH, S_FETCH, 1'($urandom), 1'b1);
      end
    endcase
  endtask

  task automatic play();
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      cur_s = it.s; cur_s0 = it.s0; cur_rst = it.rst;
      reset = it.rst; mem_ready = it.rdy;
      if (rnd_flags) begin Zero = 1'($urandom); Lt = 1'($urandom); Ltu = 1'($urandom); end
      active = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input int cls, input int f3, input bit f7, input int sf, input int sm);
    op = opc(cls); funct3 = 3'(f3); funct7b5 = f7;
    n_reg = 0; n_ir = 0; n_mw = 0; n_pc = 0; n_ill = 0; n_trap_strobe = 0;
    last_res = -1; last_alu = -1;
    build(cls, sf, sm);
    play();
  endtask

  initial begin
    int cls, k;
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    @(posedge clk); #1;
    push(S_FETCH, S_FETCH, 1'b1, 1'b1);
    push(S_FETCH, S_FETCH, 1'b0, 1'b1);
    play();
    chk("reset_state", state_dbg, 0);

    run(C_R, 0, 1'b0, 0, 0);
    chk("add_regwrite", n_reg, 1);  chk("add_pcwrite", n_pc, 1);  chk("add_alu", last_alu, 0);
    run(C_R, 0, 1'b1, 0, 0);
    chk("sub_alu", last_alu, 1);
    Zero = 1'b0; run(C_BR, 1, 1'b0, 0, 0);  chk("bne_taken_pcw", n_pc, 2);
    Zero = 1'b1; run(C_BR, 1, 1'b0, 0, 0);  chk("bne_not_pcw", n_pc, 1);
    Ltu = 1'b1;  run(C_BR, 6, 1'b0, 0, 0);  chk("bltu_taken_pcw", n_pc, 2);
    Lt = 1'b1;   run(C_BR, 2, 1'b0, 0, 0);  chk("f3_010_pcw", n_pc, 1);
    run(C_LD, 2, 1'b0, 3, 2);
    chk("lw_irwrite", n_ir, 1);  chk("lw_pcwrite", n_pc, 1);
    chk("lw_regwrite", n_reg, 1);  chk("lw_ressrc", last_res, 1);
    run(C_ST, 2, 1'b0, 0, 2);
    chk("sw_memwrite", n_mw, 3);  chk("sw_regwrite", n_reg, 0);
    run(C_JALR, 0, 1'b0, 0, 0);
    chk("jalr_pcwrite", n_pc, 2);  chk("jalr_ressrc", last_res, 2);
    run(C_LUI, 0, 1'b0, 0, 0);   chk("lui_ressrc", last_res, 3);
    run(C_AUIPC, 0, 1'b0, 0, 0); chk("auipc_ressrc", last_res, 0);
    run(C_ILL, 0, 1'b0, 0, 0);
    chk("trap_illegal_cycles", n_ill, 10);  chk("trap_strobes", n_trap_strobe, 0);
    chk("trap_reset_state", state_dbg, 0);

    rnd_flags = 1'b1;
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 9);
      if (cls == C_ILL && ($urandom % 3) != 0) cls = C_R;
      op = opc(cls); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      build(cls, $urandom_range(0, 3), $urandom_range(0, 3));
      if (($urandom % 8) == 0) begin
        k = $urandom_range(1, q.size() - 1);
        q = q[0:k-1];
        push(S_FETCH, S_FETCH, 1'($urandom), 1'b1);
      end
      play();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
